// File: rtl/rr_mux4_p.sv
// Four-input multiplexer with a one-word registered output stage and a valid/ready handshake.
// The channel comes from sel (MODE=0) or from round-robin arbitration (MODE=1).
// Define RR_MUX_GNT_CNT_EN to add a 16-bit wrapping grant counter on port gnt_cnt.
module rr_mux4_p #(
    parameter int N    = 4,
    parameter int MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in3,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in0,
    input  logic [3:0]   vld,
    output logic [3:0]   rdy_in,
    input  logic [1:0]   sel,
    output logic [N-1:0] out,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [1:0]   out_ch
`ifdef RR_MUX_GNT_CNT_EN
    ,
    output logic [15:0]  gnt_cnt
`endif
);

    // Handshake: a channel word moves into out when vld[k] and rdy_in[k] are both high at a
    // rising edge. out moves to the consumer when out_vld and out_rdy are both high. rdy_in
    // depends on the current vld, sel and out_rdy, and has at most one bit set.
    logic [1:0]   ptr;
    logic         load_en;
    logic         gnt_any;
    logic [1:0]   gnt_idx;
    logic [N-1:0] gnt_data;

    always_comb begin
        logic [1:0] cand;
        cand    = 2'd0;
        load_en = !out_vld || out_rdy;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        if (MODE == 0) begin
            gnt_idx = sel;
            gnt_any = vld[sel];
        end else begin
            // Walk from lowest to highest priority; the last match is the highest priority.
            for (int k = 4; k >= 1; k--) begin
                cand = ptr + 2'(k);
                if (vld[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (rst || !load_en) begin
            gnt_any = 1'b0;
        end
        rdy_in = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    gnt_data = in0;
            2'd1:    gnt_data = in1;
            2'd2:    gnt_data = in2;
            default: gnt_data = in3;
        endcase
    end

    // ptr resets to 3 so that channel 0 has first priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            out_vld <= 1'b0;
            out_ch  <= 2'd0;
            ptr     <= 2'd3;
        end else if (gnt_any) begin
            out     <= gnt_data;
            out_ch  <= gnt_idx;
            out_vld <= 1'b1;
            ptr     <= gnt_idx;
        end else if (load_en) begin
            out_vld <= 1'b0;
        end
    end

`ifdef RR_MUX_GNT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt <= 16'd0;
        end else if (gnt_any) begin
            gnt_cnt <= gnt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux4_p.sv
// Bench for rr_mux4_p: a MODE=0 instance and a MODE=1 instance share all inputs.
// Both instances are compared against a transaction-level model of the arbitration rules.
module tb_rr_mux4_p;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din [4];
  logic [3:0] vld;
  logic [1:0] sel;
  logic       out_rdy;
  logic [3:0] rdy_in0, rdy_in1;
  logic [3:0] out0, out1;
  logic       out_vld0, out_vld1;
  logic [1:0] out_ch0, out_ch1;
`ifdef RR_MUX_GNT_CNT_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Model state per instance: index 0 is MODE=0, index 1 is MODE=1.
  int m_out [2];
  int m_vld [2];
  int m_ch  [2];
  int m_ptr [2];
  int m_cnt [2];
  logic [3:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  rr_mux4_p #(.N(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in3(din[3]), .in2(din[2]), .in1(din[1]), .in0(din[0]),
    .vld(vld), .rdy_in(rdy_in0), .sel(sel), .out(out0), .out_vld(out_vld0),
    .out_rdy(out_rdy), .out_ch(out_ch0)
`ifdef RR_MUX_GNT_CNT_EN
    , .gnt_cnt(gnt_cnt0)
`endif
  );

  rr_mux4_p #(.N(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in3(din[3]), .in2(din[2]), .in1(din[1]), .in0(din[0]),
    .vld(vld), .rdy_in(rdy_in1), .sel(sel), .out(out1), .out_vld(out_vld1),
    .out_rdy(out_rdy), .out_ch(out_ch1)
`ifdef RR_MUX_GNT_CNT_EN
    , .gnt_cnt(gnt_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: returns the granted channel or -1.
  function automatic int model_grant(input int d);
    if (rst) return -1;
    if (m_vld[d] != 0 && !out_rdy) return -1;
    if (d == 0) return vld[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr[d] + k) % 4;
      if (vld[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_step(input int d, input int g);
    if (rst) begin
      m_out[d] = 0; m_vld[d] = 0; m_ch[d] = 0; m_ptr[d] = 3; m_cnt[d] = 0;
    end else if (g >= 0) begin
      m_out[d] = int'(din[g]); m_ch[d] = g; m_vld[d] = 1; m_ptr[d] = g;
      m_cnt[d] = (m_cnt[d] + 1) % 65536;
    end else if (m_vld[d] == 0 || out_rdy) begin
      m_vld[d] = 0;
    end
  endfunction

  // driver task: one clock cycle with the given inputs, checked against the model
  task automatic cycle(input logic r, input logic [3:0] v, input logic [1:0] s, input logic ordy);
    int g0, g1;
    logic [3:0] exp_rdy0, exp_rdy1;
    @(negedge clk);
    rst = r; vld = v; sel = s; out_rdy = ordy;
    #1;
    g0 = model_grant(0);
    g1 = model_grant(1);
    exp_rdy0 = (g0 >= 0) ? (4'b0001 << g0) : 4'b0000;
    exp_rdy1 = (g1 >= 0) ? (4'b0001 << g1) : 4'b0000;
    check("rdy_in_m0", 32'(rdy_in0), 32'(exp_rdy0));
    check("rdy_in_m1", 32'(rdy_in1), 32'(exp_rdy1));
    model_step(0, g0);
    model_step(1, g1);
    exp_q.push_back(m_out[1][3:0]);
    @(posedge clk);
    #1;
    check("out_m0", 32'(out0), 32'(m_out[0]));
    check("out_vld_m0", 32'(out_vld0), 32'(m_vld[0]));
    check("out_ch_m0", 32'(out_ch0), 32'(m_ch[0]));
    check("out_m1", 32'(out1), 32'(exp_q.pop_front()));
    check("out_vld_m1", 32'(out_vld1), 32'(m_vld[1]));
    check("out_ch_m1", 32'(out_ch1), 32'(m_ch[1]));
`ifdef RR_MUX_GNT_CNT_EN
    check("gnt_cnt_m0", 32'(gnt_cnt0), 32'(m_cnt[0]));
    check("gnt_cnt_m1", 32'(gnt_cnt1), 32'(m_cnt[1]));
`endif
  endtask

  initial begin
    int exp_ch[5];
    int exp_out[5];
    rst = 1'b1; vld = 4'b0000; sel = 2'd0; out_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_vld[i] = 0; m_ch[i] = 0; m_ptr[i] = 3; m_cnt[i] = 0;
    end
    din[3] = 4'b1111; din[2] = 4'b0111; din[1] = 4'b0011; din[0] = 4'b0001;

    // reset with every channel requesting
    cycle(1'b1, 4'b1111, 2'd0, 1'b1);
    cycle(1'b1, 4'b1111, 2'd0, 1'b1);
    check("reset_out", 32'(out1), 32'h0);
    check("reset_out_vld", 32'(out_vld1), 32'h0);
    check("reset_out_ch", 32'(out_ch1), 32'h0);

    // round robin, all requesting, full throughput
    exp_ch = '{0, 1, 2, 3, 0};
    exp_out = '{1, 3, 7, 15, 1};
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b1111, 2'd0, 1'b1);
      check("rr_ch_seq", 32'(out_ch1), 32'(exp_ch[i]));
      check("rr_out_seq", 32'(out1), 32'(exp_out[i]));
      check("rr_no_idle", 32'(out_vld1), 32'h1);
    end

    // sparse requests alternate between channels 1 and 3
    cycle(1'b1, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b1010, 2'd0, 1'b1);
      check("sparse_ch", 32'(out_ch1), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // back-pressure holds the word, then the next grant goes to channel 1
    cycle(1'b1, 4'b0000, 2'd0, 1'b1);
    cycle(1'b0, 4'b1111, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1111, 2'd0, 1'b0);
      check("bp_hold_out", 32'(out1), 32'h1);
      check("bp_hold_ch", 32'(out_ch1), 32'h0);
      check("bp_hold_rdy", 32'(rdy_in1), 32'h0);
    end
    cycle(1'b0, 4'b1111, 2'd0, 1'b1);
    check("bp_release_ch", 32'(out_ch1), 32'h1);

    // fixed select on the MODE=0 instance
    cycle(1'b1, 4'b0000, 2'd0, 1'b1);
    cycle(1'b0, 4'b0100, 2'd2, 1'b1);
    check("sel_out", 32'(out0), 32'h7);
    check("sel_ch", 32'(out0 == 4'h7 ? out_ch0 : 2'd0), 32'h2);
    cycle(1'b0, 4'b0100, 2'd1, 1'b1);
    check("sel_miss_vld", 32'(out_vld0), 32'h0);
    check("sel_miss_out", 32'(out0), 32'h7);

    // reset while a word is held discards it
    cycle(1'b0, 4'b1111, 2'd0, 1'b0);
    cycle(1'b1, 4'b1111, 2'd0, 1'b0);
    check("midrst_vld", 32'(out_vld1), 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) din[k] = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

`ifdef RR_MUX_GNT_CNT_EN
    // grant counter counts and wraps
    cycle(1'b1, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1111, 2'd0, 1'b1);
    check("cnt_four", 32'(gnt_cnt1), 32'd4);
    for (int i = 0; i < 65531; i++) cycle(1'b0, 4'b1111, 2'd0, 1'b1);
    check("cnt_max", 32'(gnt_cnt1), 32'd65535);
    cycle(1'b0, 4'b1111, 2'd0, 1'b1);
    check("cnt_wrap", 32'(gnt_cnt1), 32'd0);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/rr_mux4_p.md
RR_MUX4_P -- requirements
Module: rr_mux4_p

Interface
REQ-001 SHALL provide parameter N, default 4: width in bits of each data input and of the output.
REQ-002 SHALL provide parameter MODE, default 1: 0 selects the channel from sel, 1 uses round-robin arbitration.
REQ-003 SHALL provide port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL provide ports in3, in2, in1, in0  input  N: channel data.
REQ-006 SHALL provide port vld  input  4: per-channel valid, where bit k belongs to in<k>.
REQ-007 SHALL provide port rdy_in  output  4: per-channel accept; at most one bit high in any cycle.
REQ-008 SHALL provide port sel  input  2: channel select, used only when MODE=0.
REQ-009 SHALL provide port out  output  N: registered output data.
REQ-010 SHALL provide port out_vld  output  1: out holds a valid word.
REQ-011 SHALL provide port out_rdy  input  1: the consumer accepts out this cycle.
REQ-012 SHALL provide port out_ch  output  2: index of the channel that supplied out.

Function
REQ-013 SHALL define load_en = !out_vld || out_rdy, evaluated combinationally.
REQ-014 SHALL, when MODE=0, grant channel g = sel if and only if load_en and vld[sel] are both high.
REQ-015 SHALL, when MODE=1, grant the first channel with vld set, searching in priority order ptr+1, ptr+2, ptr+3, ptr (mod 4), and only when load_en is high.
REQ-016 SHALL drive rdy_in[g] high combinationally for the granted channel g, with all other bits low.
REQ-017 SHALL, on a grant, load out <= in<g>, out_ch <= g, out_vld <= 1 and ptr <= g at the next edge (latency 1 cycle).
REQ-018 SHALL, when load_en is high and there is no grant, clear out_vld and leave out and out_ch unchanged.
REQ-019 SHALL hold out, out_ch and out_vld stable while out_vld=1 and out_rdy=0; rdy_in SHALL be 0000 during that time.
REQ-020 SHALL, when a drain and a new grant occur in the same cycle, load the new word at that edge, sustaining full throughput of one word per cycle.
REQ-021 SHALL drop the ptr update whenever no grant occurs.
REQ-022 SHALL drive rdy_in=0000 in any cycle in which rst=1.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, set out=0, out_vld=0, out_ch=0 and ptr=3 (so channel 0 has first priority), plus gnt_cnt=0 when present.
REQ-024 SHALL discard any word held in out when reset is asserted mid-operation; no transfer SHALL complete in the reset cycle.

Configuration
REQ-025 SHALL, when macro RR_MUX_GNT_CNT_EN is defined, add port gnt_cnt  output  16, which increments by 1 on every grant and wraps from 65535 to 0.
REQ-026 SHALL, when RR_MUX_GNT_CNT_EN is undefined, have no gnt_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover reset: with N=4, rst=1 and vld=1111 for 2 cycles -> out=0000, out_vld=0, out_ch=0, rdy_in=0000.
REQ-028 SHALL cover round-robin with all channels requesting: MODE=1, in3..in0=1111/0111/0011/0001, vld=1111, out_rdy=1 -> out_ch sequence 0,1,2,3,0 and out sequence 0001, 0011, 0111, 1111, 0001, with no idle cycles.
REQ-029 SHALL cover sparse requests: MODE=1, vld=1010, out_rdy=1 -> grants alternate 1,3,1,3 and rdy_in alternates 0010/1000.
REQ-030 SHALL cover back-pressure: MODE=1, vld=1111, out_rdy=0 for 3 cycles after the first load -> out held at 0001 with out_ch=0 and rdy_in=0000; after out_rdy=1 -> the next word comes from channel 1.
REQ-031 SHALL cover fixed select: MODE=0, sel=10, vld=0100 -> out=0111, out_ch=2; then sel=01 with vld=0100 -> out_vld=0 on the next edge and out stays 0111.
REQ-032 SHALL cover the counter: with RR_MUX_GNT_CNT_EN defined, 4 grants -> gnt_cnt=4; with gnt_cnt preset via 65535 grants, one further grant -> gnt_cnt=0.
